// File: rtl/ram_fetch_controller_pkg.sv
// Shared definitions for the RAM fetch path: fetch FSM encoding, layer
// constants used by the network controller, and the per-layer base address.
package ram_fetch_controller_pkg;

    localparam int NUM_LAYERS = 3;
    localparam int LAYER_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_t;

    // Address of word 0 of a layer; callers truncate to their address width.
    function automatic int base_addr(input int layer_num, input int base, input int words);
        return base + layer_num * words;
    endfunction

endpackage

// File: rtl/ram_fetch_controller.sv
// Responder for the RAM_Controll_Start / RAM_done handshake: burst-reads one
// layer's operand words from a synchronous RAM and streams them with their index.
module ram_fetch_controller
    import ram_fetch_controller_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int ADDR_W    = 8,
    parameter  int NUM_WORDS = 4,
    parameter  int LAYERS    = NUM_LAYERS,
    parameter  int BASE_ADDR = 0,
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RAM_Controll_Start,
    input  logic [LAYER_W-1:0] layer,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              load_en,
    output logic [IDX_W-1:0]  load_idx,
    output logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              RAM_done,
    output logic              err
);

    if (NUM_WORDS < 1) begin : g_words_check
        $fatal(1, "NUM_WORDS must be at least 1");
    end
    if (longint'(LAYERS) * NUM_WORDS + BASE_ADDR > (longint'(1) << ADDR_W)) begin : g_addr_check
        $fatal(1, "layer operand block does not fit in the RAM address space");
    end

    fetch_state_t       state;
    logic [LAYER_W-1:0] layer_q;
    logic [IDX_W-1:0]   idx;

    assign load_data = ram_rdata;

    // NOTE: every register here, including the FSM state, is updated with <=
    // so all of them see pre-edge values and ordering inside the block is irrelevant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: async reset clears every flop, so an aborted fetch never reaches DONE.
            state    <= IDLE;
            layer_q  <= '0;
            idx      <= '0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            load_en  <= 1'b0;
            load_idx <= '0;
            busy     <= 1'b0;
            RAM_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            load_en  <= ram_en;
            load_idx <= idx;
            RAM_done <= 1'b0;
            err      <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (RAM_Controll_Start) begin
                        layer_q <= layer;
                        busy    <= 1'b1;
                        // A bad layer spends one busy cycle in DRAIN with nothing
                        // outstanding, so RAM_done/err land one cycle after the start.
                        if (int'(layer) >= LAYERS) begin
                            state <= DRAIN;
                        end else begin
                            ram_en   <= 1'b1;
                            ram_addr <= ADDR_W'(base_addr(int'(layer), BASE_ADDR, NUM_WORDS));
                            idx      <= '0;
                            state    <= ISSUE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                ISSUE: begin
                    if (idx == IDX_W'(NUM_WORDS - 1)) begin
                        ram_en   <= 1'b0;
                        ram_addr <= '0;
                        state    <= DRAIN;
                    end else begin
                        idx      <= idx + 1'b1;
                        ram_addr <= ram_addr + 1'b1;
                    end
                end

                DRAIN: begin
                    busy     <= 1'b0;
                    RAM_done <= 1'b1;
                    err      <= (int'(layer_q) >= LAYERS);
                    state    <= DONE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fetch_controller.sv
// Directed bench for ram_fetch_controller with a synchronous RAM model
// where mem[a] = a + 8'h10.
module tb_ram_fetch_controller;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] layer;
    logic       ram_en;
    logic [7:0] ram_addr;
    logic [7:0] ram_rdata = 8'h00;
    logic       load_en;
    logic [1:0] load_idx;
    logic [7:0] load_data;
    logic       busy;
    logic       done;
    logic       err;

    int passed = 0;
    int total  = 0;

    ram_fetch_controller #(
        .DATA_W(8), .ADDR_W(8), .NUM_WORDS(N), .LAYERS(3), .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .RAM_Controll_Start(start),
        .layer(layer),
        .ram_en(ram_en),
        .ram_addr(ram_addr),
        .ram_rdata(ram_rdata),
        .load_en(load_en),
        .load_idx(load_idx),
        .load_data(load_data),
        .busy(busy),
        .RAM_done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= ram_addr + 8'h10;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller raises start before calling; cycle c is the period after edge c.
    task automatic observe(input int exp_base, input int poke_at, input bit chain,
                           input logic [1:0] next_layer);
        tick();
        start = 1'b0;
        for (int c = 0; c <= N + 1; c++) begin
            check($sformatf("busy c%0d", c), 32'(busy), 32'(c <= N));
            check($sformatf("ram_en c%0d", c), 32'(ram_en), 32'(c < N));
            if (c < N) check($sformatf("ram_addr c%0d", c), 32'(ram_addr), exp_base + c);
            check($sformatf("load_en c%0d", c), 32'(load_en), 32'(c >= 1 && c <= N));
            if (c >= 1 && c <= N) begin
                check($sformatf("load_idx c%0d", c), 32'(load_idx), c - 1);
                check($sformatf("load_data c%0d", c), 32'(load_data), exp_base + c - 1 + 32'h10);
            end
            check($sformatf("RAM_done c%0d", c), 32'(done), 32'(c == N + 1));
            check($sformatf("err c%0d", c), 32'(err), 0);
            if (c == poke_at) begin
                start = 1'b1;
                layer = 2'd2;
            end else if (c == poke_at + 1) begin
                start = 1'b0;
            end
            if (c == N + 1 && chain) begin
                start = 1'b1;
                layer = next_layer;
            end
            if (c < N + 1 || !chain) tick();
        end
        if (!chain) check("RAM_done single", 32'(done), 0);
    endtask

    initial begin
        logic [7:0] words[$];
        int cyc;

        reset = 1'b0;
        start = 1'b0;
        layer = 2'd0;
        #12;
        check("rst busy", 32'(busy), 0);
        check("rst ram_en", 32'(ram_en), 0);
        check("rst ram_addr", 32'(ram_addr), 0);
        check("rst load_en", 32'(load_en), 0);
        check("rst load_idx", 32'(load_idx), 0);
        check("rst RAM_done", 32'(done), 0);
        check("rst err", 32'(err), 0);
        reset = 1'b1;
        tick();
        tick();

        // Layer 1: addresses 4..7, words 14..17
        start = 1'b1;
        layer = 2'd1;
        observe(4, -1, 1'b0, 2'd0);

        // Out-of-range layer 3
        start = 1'b1;
        layer = 2'd3;
        tick();
        start = 1'b0;
        check("oor c0 busy", 32'(busy), 1);
        check("oor c0 ram_en", 32'(ram_en), 0);
        check("oor c0 RAM_done", 32'(done), 0);
        tick();
        check("oor c1 RAM_done", 32'(done), 1);
        check("oor c1 err", 32'(err), 1);
        check("oor c1 busy", 32'(busy), 0);
        check("oor c1 ram_en", 32'(ram_en), 0);
        check("oor c1 load_en", 32'(load_en), 0);
        tick();
        check("oor c2 RAM_done", 32'(done), 0);
        check("oor c2 err", 32'(err), 0);

        // Layer 0 with a second start at cycle 2 that must be ignored
        start = 1'b1;
        layer = 2'd0;
        observe(0, 2, 1'b0, 2'd0);

        // Layer 0 then layer 2 started in the RAM_done cycle
        start = 1'b1;
        layer = 2'd0;
        observe(0, -1, 1'b1, 2'd2);
        observe(8, -1, 1'b0, 2'd0);

        // Asynchronous reset in cycle 3 of a fetch
        start = 1'b1;
        layer = 2'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst busy", 32'(busy), 0);
        check("arst ram_en", 32'(ram_en), 0);
        check("arst ram_addr", 32'(ram_addr), 0);
        check("arst load_en", 32'(load_en), 0);
        check("arst load_idx", 32'(load_idx), 0);
        check("arst RAM_done", 32'(done), 0);
        check("arst err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("post-rst idle %0d", i), 32'({done, busy}), 0);
        end
        start = 1'b1;
        layer = 2'd0;
        observe(0, -1, 1'b0, 2'd0);

        // Controller model: layers 0,1,2 in sequence
        for (int l = 0; l < 3; l++) begin
            words.delete();
            start = 1'b1;
            layer = 2'(l);
            tick();
            start = 1'b0;
            cyc = 0;
            while (done !== 1'b1 && cyc < 20) begin
                if (load_en) words.push_back(load_data);
                tick();
                cyc++;
            end
            check($sformatf("ctl%0d done seen", l), 32'(done), 1);
            check($sformatf("ctl%0d word count", l), 32'(words.size()), 4);
            for (int k = 0; k < 4 && k < int'(words.size()); k++)
                check($sformatf("ctl%0d word%0d", l, k), 32'(words[k]), 32'h10 + 4 * l + k);
            tick();
            check($sformatf("ctl%0d done single", l), 32'(done), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
